// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means classification datapath control.
package kmeans_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CENT,
    ST_CLASSIFY,
    ST_DRAIN,
    ST_UPDATE,
    ST_CONV_WAIT,
    ST_DONE
  } ctrl_state_e;

  localparam int unsigned RAM_RD_LAT   = 1;
  localparam int unsigned CENT_WR_DLY  = 2;
  localparam int unsigned DEF_MAX_ITER = 16;
  localparam int unsigned MAX_CENT     = 8;
  localparam int unsigned CENT_IDX_W   = 3;

  function automatic logic [MAX_CENT-1:0] onehot(input logic [CENT_IDX_W-1:0] idx);
    onehot = MAX_CENT'(1) << idx;
  endfunction

endpackage

// File: rtl/classify_addr_gen.sv
// Point RAM address counter plus the rd_en -> input_reg_en -> point_valid delay line.
module classify_addr_gen
  import kmeans_pkg::*;
#(
  parameter int unsigned addrWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [addrWidth:0]   num_points_i,
  output logic                 ram_rd_en_o,
  output logic [addrWidth-1:0] ram_addr_o,
  output logic                 input_reg_en_o,
  output logic                 point_valid_o,
  output logic                 busy_o,
  output logic                 last_c_o
);

  localparam int unsigned CNT_W = addrWidth + 1;

  logic              rd_en_q, rd_en_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic [RAM_RD_LAT:0] dly_q;

  // Extra counter bit lets N = 2^addrWidth end on the last address without wrapping.
  assign last_c_o = rd_en_q && (addr_q == (num_points_i - CNT_W'(1)));

  always_comb begin
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    if (start_i) begin
      rd_en_d = 1'b1;
      addr_d  = '0;
    end else if (rd_en_q) begin
      if (last_c_o) begin
        rd_en_d = 1'b0;
      end else begin
        addr_d = addr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      dly_q   <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      dly_q   <= {dly_q[RAM_RD_LAT-1:0], rd_en_q};
    end
  end

  assign ram_rd_en_o    = rd_en_q;
  assign ram_addr_o     = addr_q[addrWidth-1:0];
  assign input_reg_en_o = dly_q[RAM_RD_LAT-1];
  assign point_valid_o  = dly_q[RAM_RD_LAT];
  assign busy_o         = rd_en_q | (|dly_q);

endmodule

// File: rtl/classify_controller.sv
// Sequencing FSM: centroid load, point streaming, centroid update and convergence loop.
module classify_controller
  import kmeans_pkg::*;
#(
  parameter int unsigned addrWidth    = 8,
  parameter int unsigned centroid_num = 8,
  parameter int unsigned iter_width   = 8,
  parameter int unsigned pipe2_lat    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addrWidth:0]      num_points,
  input  logic [3:0]              num_cent,
  input  logic [iter_width-1:0]   max_iter,
  input  logic                    core_cent_valid,
  output logic                    core_cent_ready,
  output logic                    ram_rd_en,
  output logic [addrWidth-1:0]    ram_addr,
  output logic                    input_reg_en,
  output logic                    point_valid,
  output logic                    accum_clear,
  output logic                    first_iteration,
  output logic [centroid_num-1:0] centroid_en,
  output logic [2:0]              cent_cnt,
  input  logic                    conv_valid,
  input  logic                    converged,
  output logic [iter_width-1:0]   iter_count,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DRAIN_CYC = RAM_RD_LAT + 1 + pipe2_lat;
  localparam int unsigned CNT_W     = $clog2(DRAIN_CYC + centroid_num + 2);

  ctrl_state_e state_q, state_d;

  logic [addrWidth:0]    n_q, n_d;
  logic [3:0]            k_q, k_d;
  logic [iter_width-1:0] m_q, m_d;
  logic [iter_width-1:0] iter_q, iter_d;
  logic [CENT_IDX_W-1:0] load_idx_q, load_idx_d;
  logic [CENT_IDX_W-1:0] cent_cnt_q, cent_cnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CENT_IDX_W-1:0] k_last;

  logic busy_q, ready_q, first_q, done_q, clear_q;
  logic wr_stage0;
  logic [CENT_WR_DLY-1:0]                 wr_vld_q;
  logic [CENT_WR_DLY-1:0][CENT_IDX_W-1:0] wr_idx_q;

  logic addr_start, addr_last, addr_busy;

  assign k_last = CENT_IDX_W'(k_q - 4'd1);

  // Next state and counters.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    m_d        = m_q;
    iter_d     = iter_q;
    load_idx_d = load_idx_q;
    cent_cnt_d = '0;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d        = num_points;
          k_d        = num_cent;
          m_d        = (max_iter == '0) ? iter_width'(DEF_MAX_ITER) : max_iter;
          iter_d     = '0;
          load_idx_d = '0;
          state_d    = ST_LOAD_CENT;
        end
      end
      ST_LOAD_CENT: begin
        if (core_cent_valid) begin
          if (load_idx_q == k_last) begin
            load_idx_d = '0;
            state_d    = ST_CLASSIFY;
          end else begin
            load_idx_d = load_idx_q + CENT_IDX_W'(1);
          end
        end
      end
      ST_CLASSIFY: begin
        if (addr_last) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_UPDATE: begin
        // Index holds at K-1 while the last two delayed writes drain.
        cent_cnt_d = (cent_cnt_q == k_last) ? cent_cnt_q : cent_cnt_q + CENT_IDX_W'(1);
        if (cnt_q == CNT_W'(k_q) + CNT_W'(1)) begin
          cent_cnt_d = '0;
          state_d    = ST_CONV_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CONV_WAIT: begin
        if (conv_valid) begin
          iter_d  = iter_q + iter_width'(1);
          state_d = (converged || (iter_d == m_q)) ? ST_DONE : ST_CLASSIFY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr_start = (state_d == ST_CLASSIFY) && (state_q != ST_CLASSIFY);
  assign wr_stage0  = (state_q == ST_UPDATE) && (cnt_q < CNT_W'(k_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      m_q        <= '0;
      iter_q     <= '0;
      load_idx_q <= '0;
      cent_cnt_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      clear_q    <= 1'b0;
      wr_vld_q   <= '0;
      wr_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      m_q        <= m_d;
      iter_q     <= iter_d;
      load_idx_q <= load_idx_d;
      cent_cnt_q <= cent_cnt_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != ST_IDLE);
      ready_q    <= (state_d == ST_LOAD_CENT);
      first_q    <= (state_d == ST_LOAD_CENT);
      done_q     <= (state_d == ST_DONE);
      clear_q    <= addr_start;
      // Delay update writes to line up with the pipe's internal cent_cnt delay.
      wr_vld_q   <= {wr_vld_q[CENT_WR_DLY-2:0], wr_stage0};
      wr_idx_q   <= {wr_idx_q[CENT_WR_DLY-2:0], cent_cnt_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_UPDATE) begin
      assert (!addr_busy);
    end
  end

  classify_addr_gen #(
    .addrWidth(addrWidth)
  ) u_addr_gen (
    .clk            (clk),
    .rst            (rst),
    .start_i        (addr_start),
    .num_points_i   (n_q),
    .ram_rd_en_o    (ram_rd_en),
    .ram_addr_o     (ram_addr),
    .input_reg_en_o (input_reg_en),
    .point_valid_o  (point_valid),
    .busy_o         (addr_busy),
    .last_c_o       (addr_last)
  );

  // Initial-load writes follow core_cent_valid in the same cycle.
  assign centroid_en =
      (((state_q == ST_LOAD_CENT) && core_cent_valid) ? centroid_num'(onehot(load_idx_q)) : '0) |
      (wr_vld_q[CENT_WR_DLY-1] ? centroid_num'(onehot(wr_idx_q[CENT_WR_DLY-1])) : '0);

  assign core_cent_ready = ready_q;
  assign first_iteration = first_q;
  assign accum_clear     = clear_q;
  assign cent_cnt        = cent_cnt_q;
  assign iter_count      = iter_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_classify_controller.sv
// Directed bench for classify_controller: per-cycle schedule model driven by a vector table.
module tb_classify_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] num_points;
  logic [3:0] num_cent;
  logic [7:0] max_iter;
  logic       core_cent_valid;
  logic       core_cent_ready;
  logic       ram_rd_en;
  logic [7:0] ram_addr;
  logic       input_reg_en;
  logic       point_valid;
  logic       accum_clear;
  logic       first_iteration;
  logic [7:0] centroid_en;
  logic [2:0] cent_cnt;
  logic       conv_valid;
  logic       converged;
  logic [7:0] iter_count;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         n;
    int         k;
    int         m;
    int         conv_at;
    logic [7:0] vmask;
    bit         noise;
    int         exp_iter;
    int         exp_done;
  } vec_t;

  vec_t vt[7];

  classify_controller #(
    .addrWidth(8), .centroid_num(8), .iter_width(8), .pipe2_lat(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_points(num_points), .num_cent(num_cent),
    .max_iter(max_iter), .core_cent_valid(core_cent_valid), .core_cent_ready(core_cent_ready),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .input_reg_en(input_reg_en),
    .point_valid(point_valid), .accum_clear(accum_clear), .first_iteration(first_iteration),
    .centroid_en(centroid_en), .cent_cnt(cent_cnt), .conv_valid(conv_valid),
    .converged(converged), .iter_count(iter_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=0 act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int cyc, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec(input logic [7:0] addr_m, input logic [7:0] iter_m);
    out_vec = 64'({busy, core_cent_ready, first_iteration, ram_rd_en, input_reg_en,
                   point_valid, accum_clear, done, centroid_en, cent_cnt, iter_m, addr_m});
  endfunction

  // Cycle 0 is the start cycle; LOAD follows, then passes of length N+K+7 from 'base'.
  task automatic run_vec(input int idx, input vec_t v);
    int L, loaded, base, p, r, j, done_c, iters, act_done, act_iter;
    logic vld, e_busy, e_rdy, e_first, e_rd, e_ire, e_pv, e_clr, e_done;
    logic [7:0] e_cen, e_iter, e_addr, a_addr, a_iter;
    logic [2:0] e_cc;
    bit finished;
    L = v.n + v.k + 7;
    loaded = 0; base = -1; p = 0; r = 0; done_c = -1; iters = 0;
    act_done = -1; act_iter = -1; finished = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (base >= 0 && c >= base) begin
        p = (c - base) / L;
        r = (c - base) % L;
      end
      vld             = (c >= 1 && c <= 8) ? v.vmask[c-1] : 1'b1;
      start           = (c == 0) || (v.noise && done_c < 0 && (c % 37) == 5);
      num_points      = 9'(v.n);
      num_cent        = 4'(v.k);
      max_iter        = 8'(v.m);
      core_cent_valid = vld;
      conv_valid      = 1'b1;
      converged       = (v.conv_at != 0) && (p + 1 == v.conv_at);
      #1;
      {e_busy, e_rdy, e_first, e_rd, e_ire, e_pv, e_clr, e_done} = '0;
      e_cen = '0; e_cc = '0; e_iter = '0; e_addr = '0;
      if (done_c >= 0 && c == done_c) begin
        e_busy = 1'b1; e_done = 1'b1; e_iter = 8'(iters);
      end else if (done_c >= 0 && c == done_c + 1) begin
        e_iter = 8'(iters); finished = 1;
      end else if (c == 0) begin
        e_busy = 1'b0;
      end else if (base < 0) begin
        e_busy = 1'b1; e_rdy = 1'b1; e_first = 1'b1;
        if (vld) begin
          e_cen = 8'(1) << loaded;
          loaded++;
          if (loaded == v.k) base = c + 1;
        end
      end else begin
        e_busy = 1'b1;
        e_iter = 8'(p);
        e_rd   = (r < v.n);
        e_addr = e_rd ? 8'(r) : 8'h0;
        e_clr  = (r == 0);
        e_ire  = (r >= 1) && (r <= v.n);
        e_pv   = (r >= 2) && (r <= v.n + 1);
        j = r - (v.n + 4);
        if (j >= 0 && j <= v.k + 1) begin
          e_cc = (j < v.k) ? 3'(j) : 3'(v.k - 1);
          if (j >= 2) e_cen = 8'(1) << (j - 2);
        end
        if (r == L - 1 && (converged || p + 1 == v.m)) begin
          iters  = p + 1;
          done_c = c + 1;
        end
      end
      if (done === 1'b1 && act_done < 0) begin
        act_done = c;
        act_iter = int'(iter_count);
      end
      a_addr = e_rd ? ram_addr : 8'h0;
      a_iter = (c == 0) ? 8'h0 : iter_count;
      check($sformatf("v%0d_cycle", idx), c, out_vec(a_addr, a_iter),
            64'({e_busy, e_rdy, e_first, e_rd, e_ire, e_pv, e_clr, e_done,
                 e_cen, e_cc, e_iter, e_addr}));
      if (finished) break;
    end
    start = 1'b0;
    if (!finished) check($sformatf("v%0d_timeout", idx), 0, 64'(0), 64'(1));
    check($sformatf("v%0d_done_cycle", idx), 0, 64'(act_done), 64'(v.exp_done));
    check($sformatf("v%0d_iters", idx), 0, 64'(act_iter), 64'(v.exp_iter));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_points = '0; num_cent = '0; max_iter = '0;
    core_cent_valid = 1'b0; conv_valid = 1'b0; converged = 1'b0;

    vt[0] = '{n:4,   k:2, m:5, conv_at:2, vmask:8'hFF, noise:0, exp_iter:2, exp_done:29};
    vt[1] = '{n:5,   k:3, m:1, conv_at:0, vmask:8'h0D, noise:0, exp_iter:1, exp_done:20};
    vt[2] = '{n:5,   k:3, m:3, conv_at:0, vmask:8'hFF, noise:0, exp_iter:3, exp_done:49};
    vt[3] = '{n:1,   k:1, m:1, conv_at:0, vmask:8'hFF, noise:0, exp_iter:1, exp_done:11};
    vt[4] = '{n:3,   k:8, m:3, conv_at:0, vmask:8'hFF, noise:0, exp_iter:3, exp_done:63};
    vt[5] = '{n:256, k:1, m:1, conv_at:0, vmask:8'hFF, noise:1, exp_iter:1, exp_done:266};
    vt[6] = '{n:2,   k:4, m:2, conv_at:1, vmask:8'hFF, noise:0, exp_iter:1, exp_done:18};

    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 0, out_vec(ram_addr, iter_count), 64'(0));
    rst = 1'b0;

    // Reset while streaming a long point set.
    @(posedge clk); #1;
    start = 1'b1; num_points = 9'd200; num_cent = 4'd2; max_iter = 8'd1;
    core_cent_valid = 1'b1; conv_valid = 1'b0;
    repeat (49) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #2;
    check("mid_classify_addr", 50, 64'({ram_rd_en, ram_addr}), 64'({1'b1, 8'd47}));
    rst = 1'b1;
    @(posedge clk); #2;
    check("mid_reset_outputs", 51, out_vec(ram_addr, iter_count), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("post_reset_quiet", 52 + i,
            64'({ram_rd_en, input_reg_en, point_valid, centroid_en, busy, done}), 64'(0));
    end

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    @(posedge clk); #2;
    check("final_idle", 0, 64'({busy, done, ram_rd_en, centroid_en}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
